// File: rtl/gpio_cmd_bridge.sv
// GPIO command bridge: toggle-handshake command decoder between the soft micro's GPIO pair
// and the convolution datapath, with a result FIFO drained by POP commands.
module gpio_cmd_bridge #(
    parameter int unsigned GPIO_D      = 32,
    parameter int unsigned BITS_IMAGEN = 8,
    parameter int unsigned BITS_DATA   = 13,
    parameter int unsigned NB_ADDRESS  = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_CYCLES  = 4
) (
    input  logic                   CLK100MHZ,
    input  logic                   i_reset,
    input  logic [GPIO_D-1:0]      i_gpio,
    output logic [GPIO_D-1:0]      o_gpio,
    output logic                   o_soft_rst,
    output logic                   o_sop,
    output logic                   o_valid,
    output logic                   o_load,
    output logic                   o_ki,
    output logic [BITS_IMAGEN-1:0] o_data,
    output logic [NB_ADDRESS-1:0]  o_imglen,
    input  logic                   i_eop,
    input  logic                   i_res_valid,
    input  logic [BITS_DATA-1:0]   i_res_data,
    output logic                   o_led
);

    localparam int unsigned CmdW = 4 + BITS_IMAGEN;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RcW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [2:0] OpNop     = 3'd0;
    localparam logic [2:0] OpSoftRst = 3'd1;
    localparam logic [2:0] OpSetLen  = 3'd2;
    localparam logic [2:0] OpLoadK   = 3'd3;
    localparam logic [2:0] OpLoadI   = 3'd4;
    localparam logic [2:0] OpStart   = 3'd5;
    localparam logic [2:0] OpPop     = 3'd6;
    localparam logic [2:0] OpClrErr  = 3'd7;

    typedef enum logic [1:0] {StIdle, StExec, StRstHold} state_e;

    state_e                 state_q, state_d;
    logic [CmdW-1:0]        sync_q [SYNC_STAGES];
    logic [CmdW-1:0]        sync_d [SYNC_STAGES];
    logic                   lt_q, lt_d;
    logic [2:0]             op_q, op_d;
    logic [BITS_IMAGEN-1:0] pay_q, pay_d;
    logic [RcW-1:0]         rst_cnt_q, rst_cnt_d;

    logic                   soft_rst_q, soft_rst_d;
    logic                   sop_q, sop_d;
    logic                   valid_q, valid_d;
    logic                   load_q, load_d;
    logic                   ki_q, ki_d;
    logic [BITS_IMAGEN-1:0] data_q, data_d;
    logic [NB_ADDRESS-1:0]  imglen_q, imglen_d;

    logic                   eop_seen_q, eop_seen_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic [BITS_DATA-1:0]   rd_data_q, rd_data_d;

    logic [BITS_DATA-1:0]   mem_q [FIFO_DEPTH];
    logic [BITS_DATA-1:0]   mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;

    logic                   sync_t;
    logic [2:0]             sync_op;
    logic [BITS_IMAGEN-1:0] sync_pay;
    logic                   accept;
    logic                   exec;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   do_push;
    logic                   do_pop;
    logic                   unused_gpio;

    // Bits between the opcode field and the payload carry nothing.
    assign unused_gpio = ^i_gpio[GPIO_D-5:BITS_IMAGEN];

    assign sync_t   = sync_q[SYNC_STAGES-1][CmdW-1];
    assign sync_op  = sync_q[SYNC_STAGES-1][CmdW-2 -: 3];
    assign sync_pay = sync_q[SYNC_STAGES-1][BITS_IMAGEN-1:0];

    assign accept     = (state_q == StIdle) && (sync_t != lt_q);
    assign exec       = (state_q == StExec);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));

    always_comb begin
        sync_d[0] = {i_gpio[GPIO_D-1 -: 4], i_gpio[BITS_IMAGEN-1:0]};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // FSM: next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StExec;
            StExec:    state_d = (op_q == OpSoftRst) ? StRstHold : StIdle;
            StRstHold: if (rst_cnt_q == RcW'(RST_CYCLES - 1)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs and command side effects, registered one cycle after EXEC
    always_comb begin
        lt_d       = lt_q;
        op_d       = op_q;
        pay_d      = pay_q;
        rst_cnt_d  = (state_q == StRstHold) ? rst_cnt_q + RcW'(1) : '0;
        soft_rst_d = (state_q == StRstHold);
        sop_d      = 1'b0;
        valid_d    = 1'b0;
        load_d     = 1'b0;
        ki_d       = ki_q;
        data_d     = data_q;
        imglen_d   = imglen_q;
        eop_seen_d = eop_seen_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (accept) begin
            lt_d  = sync_t;
            op_d  = sync_op;
            pay_d = sync_pay;
        end

        if (exec) begin
            unique case (op_q)
                OpNop: ;
                OpSoftRst: begin
                    eop_seen_d = 1'b0;
                    ovf_d      = 1'b0;
                    udf_d      = 1'b0;
                end
                OpSetLen: imglen_d = pay_q[NB_ADDRESS-1:0];
                OpLoadK: begin
                    ki_d    = 1'b1;
                    data_d  = pay_q;
                    load_d  = 1'b1;
                    valid_d = 1'b1;
                end
                OpLoadI: begin
                    ki_d    = 1'b0;
                    data_d  = pay_q;
                    valid_d = 1'b1;
                end
                OpStart: begin
                    sop_d      = 1'b1;
                    eop_seen_d = 1'b0;
                end
                OpPop:    if (fifo_empty) udf_d = 1'b1;
                OpClrErr: begin
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (i_eop) eop_seen_d = 1'b1;
        if (i_res_valid && fifo_full && !do_pop) ovf_d = 1'b1;
    end

    // Result FIFO; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        do_pop    = exec && (op_q == OpPop) && !fifo_empty;
        do_push   = i_res_valid && (!fifo_full || do_pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = i_res_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end

        if (exec && (op_q == OpSoftRst)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            lt_q       <= 1'b0;
            op_q       <= OpNop;
            pay_q      <= '0;
            rst_cnt_q  <= '0;
            soft_rst_q <= 1'b0;
            sop_q      <= 1'b0;
            valid_q    <= 1'b0;
            load_q     <= 1'b0;
            ki_q       <= 1'b1;
            data_q     <= '0;
            imglen_q   <= '1;
            eop_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            lt_q       <= lt_d;
            op_q       <= op_d;
            pay_q      <= pay_d;
            rst_cnt_q  <= rst_cnt_d;
            soft_rst_q <= soft_rst_d;
            sop_q      <= sop_d;
            valid_q    <= valid_d;
            load_q     <= load_d;
            ki_q       <= ki_d;
            data_q     <= data_d;
            imglen_q   <= imglen_d;
            eop_seen_q <= eop_seen_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_data_q  <= rd_data_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        o_gpio                  = '0;
        o_gpio[GPIO_D-1]        = lt_q;
        o_gpio[GPIO_D-2]        = eop_seen_q;
        o_gpio[GPIO_D-3]        = fifo_empty;
        o_gpio[GPIO_D-4]        = fifo_full;
        o_gpio[GPIO_D-5]        = ovf_q;
        o_gpio[GPIO_D-6]        = udf_q;
        o_gpio[BITS_DATA-1:0]   = rd_data_q;
    end

    assign o_soft_rst = soft_rst_q;
    assign o_sop      = sop_q;
    assign o_valid    = valid_q;
    assign o_load     = load_q;
    assign o_ki       = ki_q;
    assign o_data     = data_q;
    assign o_imglen   = imglen_q;
    assign o_led      = eop_seen_q;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// Scoreboard bench for gpio_cmd_bridge: pulse expectations and a FIFO model are queued as
// commands/results are driven and compared as the bridge responds.
module tb_gpio_cmd_bridge;

    localparam int S     = 2;
    localparam int RC    = 4;
    localparam int DEPTH = 8;

    localparam logic [2:0] OpNop     = 3'd0;
    localparam logic [2:0] OpSoftRst = 3'd1;
    localparam logic [2:0] OpSetLen  = 3'd2;
    localparam logic [2:0] OpLoadK   = 3'd3;
    localparam logic [2:0] OpLoadI   = 3'd4;
    localparam logic [2:0] OpStart   = 3'd5;
    localparam logic [2:0] OpPop     = 3'd6;
    localparam logic [2:0] OpClrErr  = 3'd7;

    localparam int BAck = 31, BEop = 30, BEmp = 29, BFull = 28, BOvf = 27, BUdf = 26;

    typedef struct {
        int         cyc;
        logic       load;
        logic       valid;
        logic       sop;
        logic       ki;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_gpio;
    logic [31:0] o_gpio;
    logic        o_soft_rst, o_sop, o_valid, o_load, o_ki, o_led;
    logic [7:0]  o_data;
    logic [3:0]  o_imglen;
    logic        i_eop;
    logic        i_res_valid;
    logic [12:0] i_res_data;

    always #5 clk = ~clk;

    gpio_cmd_bridge #(
        .GPIO_D     (32),
        .BITS_IMAGEN(8),
        .BITS_DATA  (13),
        .NB_ADDRESS (4),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(S),
        .RST_CYCLES (RC)
    ) dut (
        .CLK100MHZ  (clk),
        .i_reset    (i_reset),
        .i_gpio     (i_gpio),
        .o_gpio     (o_gpio),
        .o_soft_rst (o_soft_rst),
        .o_sop      (o_sop),
        .o_valid    (o_valid),
        .o_load     (o_load),
        .o_ki       (o_ki),
        .o_data     (o_data),
        .o_imglen   (o_imglen),
        .i_eop      (i_eop),
        .i_res_valid(i_res_valid),
        .i_res_data (i_res_data),
        .o_led      (o_led)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    logic [12:0] fifo_m[$];
    logic [12:0] rd_exp = '0;
    logic        t_reg = 1'b0;
    int          sr_first = -1;
    int          sr_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic l, input logic v, input logic s,
                                input logic k, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.load = l; e.valid = v; e.sop = s; e.ki = k; e.data = d;
        return e;
    endfunction

    // Pulse monitor: every datapath pulse must match the head of the expectation queue.
    initial forever begin
        @(negedge clk);
        if (i_reset && (o_load || o_valid || o_sop)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {29'd0, o_load, o_valid, o_sop}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("pulse_kind", {29'd0, o_load, o_valid, o_sop},
                         {29'd0, e.load, e.valid, e.sop});
                check_eq("pulse_data", {24'd0, o_data}, {24'd0, e.data});
                check_eq("pulse_ki", {31'd0, o_ki}, {31'd0, e.ki});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (o_soft_rst) begin
            if (sr_first < 0) sr_first = cyc;
            sr_len++;
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] pay, input bit settle,
                            input bit has_exp, input exp_t e, output int issue);
        exp_t ee;
        bit   got;
        @(posedge clk); #1;
        t_reg  = ~t_reg;
        i_gpio = {t_reg, op, 20'($urandom), pay};
        issue  = cyc;
        if (has_exp) begin
            ee     = e;
            ee.cyc = issue + e.cyc;
            exp_q.push_back(ee);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (o_gpio[BAck] == t_reg) got = 1'b1;
        end
        check_eq("ack", {31'd0, got}, 32'd1);
        if (settle) begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_res(input logic [12:0] d);
        @(posedge clk); #1;
        i_res_valid = 1'b1;
        i_res_data  = d;
        if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
        @(posedge clk); #1;
        i_res_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        int   c;
        logic uf;
        uf = 1'b0;
        if (fifo_m.size() > 0) rd_exp = fifo_m.pop_front();
        else uf = 1'b1;
        send_cmd(OpPop, 8'h00, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), c);
        check_eq(tag, {19'd0, o_gpio[12:0]}, {19'd0, rd_exp});
        if (uf) check_eq({tag, "_underflow"}, {31'd0, o_gpio[BUdf]}, 32'd1);
    endtask

    task automatic pulse_eop();
        @(posedge clk); #1;
        i_eop = 1'b1;
        @(posedge clk); #1;
        i_eop = 1'b0;
    endtask

    initial begin
        int   c, c_sr;
        exp_t none;
        bit   got;
        none        = mk(0, 0, 0, 0, 0, 0);
        i_reset     = 1'b0;
        i_gpio      = '0;
        i_eop       = 1'b0;
        i_res_valid = 1'b0;
        i_res_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_gpio", o_gpio, 32'h2000_0000);
        check_eq("rst_imglen", {28'd0, o_imglen}, 32'hF);
        check_eq("rst_ki", {31'd0, o_ki}, 32'd1);
        check_eq("rst_pulses", {28'd0, o_load, o_valid, o_sop, o_soft_rst}, 32'd0);
        check_eq("rst_led", {31'd0, o_led}, 32'd0);

        // Kernel load
        send_cmd(OpLoadK, 8'h55, 1'b1, 1'b1, mk(S + 2, 1, 1, 0, 1, 8'h55), c);
        check_eq("loadk_data", {24'd0, o_data}, 32'h55);
        check_eq("loadk_ki", {31'd0, o_ki}, 32'd1);
        check_eq("loadk_ack", {31'd0, o_gpio[BAck]}, 32'd1);

        // Length, EoP sticky and start
        send_cmd(OpSetLen, 8'hF9, 1'b1, 1'b0, none, c);
        check_eq("imglen", {28'd0, o_imglen}, 32'h9);
        pulse_eop();
        check_eq("eop_set", {31'd0, o_gpio[BEop]}, 32'd1);
        check_eq("led_set", {31'd0, o_led}, 32'd1);
        send_cmd(OpStart, 8'h00, 1'b1, 1'b1, mk(S + 2, 0, 0, 1, 1, 8'h55), c);
        check_eq("eop_clr", {31'd0, o_gpio[BEop]}, 32'd0);
        check_eq("led_clr", {31'd0, o_led}, 32'd0);
        send_cmd(OpLoadI, 8'hA3, 1'b1, 1'b1, mk(S + 2, 0, 1, 0, 0, 8'hA3), c);
        check_eq("loadi_ki_hold", {31'd0, o_ki}, 32'd0);
        send_cmd(OpNop, 8'h77, 1'b1, 1'b0, none, c);
        check_eq("nop_data_hold", {24'd0, o_data}, 32'hA3);

        // FIFO pops and underflow
        push_res(13'h0123);
        push_res(13'h0ABC);
        push_res(13'h1FFF);
        check_eq("fifo_nonempty", {31'd0, o_gpio[BEmp]}, 32'd0);
        pop_check("pop0");
        pop_check("pop1");
        pop_check("pop2");
        check_eq("fifo_empty", {31'd0, o_gpio[BEmp]}, 32'd1);
        pop_check("pop_empty");
        send_cmd(OpClrErr, 8'h00, 1'b1, 1'b0, none, c);
        check_eq("udf_clr", {31'd0, o_gpio[BUdf]}, 32'd0);

        // Overflow, then simultaneous push+pop while full
        for (int i = 0; i < 9; i++) push_res(13'h100 + 13'(i));
        check_eq("full", {31'd0, o_gpio[BFull]}, 32'd1);
        check_eq("ovf_set", {31'd0, o_gpio[BOvf]}, 32'd1);
        send_cmd(OpClrErr, 8'h00, 1'b1, 1'b0, none, c);
        check_eq("ovf_clr", {31'd0, o_gpio[BOvf]}, 32'd0);
        send_cmd(OpPop, 8'h00, 1'b0, 1'b0, none, c);
        i_res_valid = 1'b1;
        i_res_data  = 13'h0F0F;
        rd_exp      = fifo_m.pop_front();
        fifo_m.push_back(13'h0F0F);
        @(posedge clk); #1;
        i_res_valid = 1'b0;
        check_eq("pushpop_rd", {19'd0, o_gpio[12:0]}, {19'd0, rd_exp});
        check_eq("pushpop_full", {31'd0, o_gpio[BFull]}, 32'd1);
        check_eq("pushpop_no_ovf", {31'd0, o_gpio[BOvf]}, 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
        check_eq("drain_empty", {31'd0, o_gpio[BEmp]}, 32'd1);
        check_eq("drain_no_udf", {31'd0, o_gpio[BUdf]}, 32'd0);

        // Soft reset with a command queued during the hold
        push_res(13'h0042);
        push_res(13'h0043);
        pulse_eop();
        sr_first = -1;
        sr_len   = 0;
        send_cmd(OpSoftRst, 8'h00, 1'b0, 1'b0, none, c_sr);
        exp_q.push_back(mk(c_sr + S + RC + 4, 0, 1, 0, 0, 8'h3C));
        send_cmd(OpLoadI, 8'h3C, 1'b1, 1'b0, none, c);
        repeat (4) @(posedge clk);
        #1;
        check_eq("softrst_len", sr_len, RC);
        check_eq("softrst_start", sr_first, c_sr + S + 3);
        fifo_m.delete();
        check_eq("softrst_flush", {31'd0, o_gpio[BEmp]}, 32'd1);
        check_eq("softrst_eop_clr", {31'd0, o_gpio[BEop]}, 32'd0);
        check_eq("softrst_imglen", {28'd0, o_imglen}, 32'h9);
        check_eq("queued_data", {24'd0, o_data}, 32'h3C);

        // Reset during hold, with a pending toggle accepted afterwards
        send_cmd(OpSoftRst, 8'h00, 1'b0, 1'b0, none, c);
        @(posedge clk); #1;
        t_reg   = 1'b1;
        i_gpio  = {1'b1, OpNop, 28'd0};
        i_reset = 1'b0;
        @(posedge clk); #1;
        check_eq("midhold_softrst", {31'd0, o_soft_rst}, 32'd0);
        check_eq("midhold_gpio", o_gpio, 32'h2000_0000);
        check_eq("midhold_imglen", {28'd0, o_imglen}, 32'hF);
        i_reset = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (o_gpio[BAck]) got = 1'b1;
        end
        check_eq("pending_after_reset", {31'd0, got}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_soft_rst_after", {31'd0, o_soft_rst}, 32'd0);
        check_eq("exp_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
